program_loader: RTL and testbench

- Host-side initiator for the processor's `load_program` bus. Takes a framed byte stream (UART RX or test host) and turns it into 32-bit load strobes that write program words into processor memory.
- Sequences the processor reset around the load, releases the processor to run after a valid frame, then monitors `done`.
- Sits between the byte-stream source and the processor top; owns the processor's reset input.

---
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to load_program strobes, with processor reset sequencing
// Parses HEADER/count/address/data/checksum frames, writes each word, then releases the processor.
module program_loader #(
    parameter int          HOLD_CYCLES = 2,
    parameter int          RST_CYCLES  = 4,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] load_program,
    output logic        cpu_rst_n,
    input  logic        cpu_done,
    output logic        busy,
    output logic        load_ok,
    output logic [1:0]  err_code,
    output logic [11:0] words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE, S_CNT_H, S_CNT_L, S_ADR_H, S_ADR_L, S_DAT_H, S_DAT_L,
        S_WRITE, S_CHK, S_CPU_RST, S_RUN, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [11:0] rem_q, rem_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  dat_h_q, dat_h_d;
    logic [7:0]  sum_q, sum_d;
    logic [11:0] words_q, words_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] lp_q, lp_d;

    logic       take;
    logic       restart;
    logic [7:0] sum_add;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            dat_h_q <= '0;
            sum_q   <= '0;
            words_q <= '0;
            err_q   <= '0;
            lp_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            dat_h_q <= dat_h_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            err_q   <= err_d;
            lp_q    <= lp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        dat_h_d  = dat_h_q;
        sum_d    = sum_q;
        words_d  = words_q;
        err_d    = err_q;
        lp_d     = lp_q;
        rx_ready = !(state_q == S_WRITE || state_q == S_CPU_RST);
        take     = rx_valid && rx_ready;
        sum_add  = sum_q + rx_data;
        restart  = take && (rx_data == HEADER) &&
                   (state_q == S_IDLE || state_q == S_RUN || state_q == S_DONE || state_q == S_ERR);

        case (state_q)
            S_CNT_H: if (take) begin
                sum_d = sum_add;
                rem_d = {rx_data[3:0], rem_q[7:0]};
                if (rx_data[7:4] != 4'd0) begin
                    state_d = S_ERR;
                    err_d   = 2'd1;
                end else begin
                    state_d = S_CNT_L;
                end
            end
            S_CNT_L: if (take) begin
                sum_d   = sum_add;
                rem_d   = {rem_q[11:8], rx_data};
                state_d = S_ADR_H;
            end
            S_ADR_H: if (take) begin
                sum_d  = sum_add;
                addr_d = {rx_data[3:0], addr_q[7:0]};
                if (rx_data[7:4] != 4'd0) begin
                    state_d = S_ERR;
                    err_d   = 2'd1;
                end else begin
                    state_d = S_ADR_L;
                end
            end
            S_ADR_L: if (take) begin
                sum_d   = sum_add;
                addr_d  = {addr_q[11:8], rx_data};
                state_d = (rem_q == 12'd0) ? S_CHK : S_DAT_H;
            end
            S_DAT_H: if (take) begin
                sum_d   = sum_add;
                dat_h_d = rx_data;
                state_d = S_DAT_L;
            end
            S_DAT_L: if (take) begin
                sum_d   = sum_add;
                lp_d    = {1'b1, 3'b000, addr_q, dat_h_q, rx_data};
                timer_d = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // One cycle arms the processor's load path, the remaining cycles write.
                if (timer_q == 16'(HOLD_CYCLES - 1)) begin
                    lp_d[31] = 1'b0;
                    addr_d   = addr_q + 12'd1;
                    words_d  = words_q + 12'd1;
                    rem_d    = rem_q - 12'd1;
                    state_d  = (rem_q == 12'd1) ? S_CHK : S_DAT_H;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_CHK: if (take) begin
                if (sum_add == 8'd0) begin
                    timer_d = '0;
                    state_d = S_CPU_RST;
                end else begin
                    err_d   = 2'd2;
                    state_d = S_ERR;
                end
            end
            S_CPU_RST: begin
                if (timer_q == 16'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RUN: if (cpu_done) state_d = S_DONE;
            S_IDLE, S_DONE, S_ERR: ;
            default: state_d = S_IDLE;
        endcase

        // A header in a resting state aborts whatever ran before and begins a new frame.
        if (restart) begin
            state_d = S_CNT_H;
            sum_d   = '0;
            words_d = '0;
            err_d   = '0;
        end
    end

    assign load_program = lp_q;
    assign cpu_rst_n    = (state_q == S_WRITE) || (state_q == S_RUN) || (state_q == S_DONE);
    assign load_ok      = (state_q == S_RUN) || (state_q == S_DONE);
    assign busy         = !(state_q == S_IDLE || state_q == S_RUN || state_q == S_DONE || state_q == S_ERR);
    assign err_code     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized frame stimulus checked against a frame-level reference model
module tb_program_loader;

    localparam int HOLD = 2;
    localparam int RST  = 4;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] load_program;
    logic        cpu_rst_n;
    logic        cpu_done = 1'b0;
    logic        busy;
    logic        load_ok;
    logic [1:0]  err_code;
    logic [11:0] words_loaded;

    always #5 clk = ~clk;

    program_loader #(.HOLD_CYCLES(HOLD), .RST_CYCLES(RST), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .load_program(load_program), .cpu_rst_n(cpu_rst_n), .cpu_done(cpu_done), .busy(busy),
        .load_ok(load_ok), .err_code(err_code), .words_loaded(words_loaded)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  exp_err;
    logic        exp_ok;
    logic [11:0] exp_words;
    bit          mon_en = 1'b0;
    int          hold_run = 0;
    int          rst_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] at(input bq_t f, input int i);
        return (i < f.size()) ? f[i] : 8'd0;
    endfunction

    // Frame-level reference: which words get written, final error, whether the processor runs.
    task automatic model_frame(input bq_t f);
        int i;
        int cnt;
        logic [7:0] ch, cl, ah, al, dh, dl, sum;
        logic [11:0] a;
        exp_err = 2'd0; exp_ok = 1'b0; exp_words = 12'd0; i = 0;
        while (i < f.size() && f[i] != 8'hA5) i++;
        i++;
        ch = at(f, i); i++;
        if (ch[7:4] != 4'd0) begin exp_err = 2'd1; return; end
        cl = at(f, i); i++;
        ah = at(f, i); i++;
        if (ah[7:4] != 4'd0) begin exp_err = 2'd1; return; end
        al = at(f, i); i++;
        cnt = int'({ch[3:0], cl});
        a = {ah[3:0], al};
        sum = ch + cl + ah + al;
        for (int k = 0; k < cnt; k++) begin
            dh = at(f, i); i++;
            dl = at(f, i); i++;
            exp_q.push_back({4'b1000, a, dh, dl});
            a = a + 12'd1;
            sum = sum + dh + dl;
            exp_words = exp_words + 12'd1;
        end
        sum = sum + at(f, i);
        exp_ok = (sum == 8'd0);
        exp_err = exp_ok ? 2'd0 : 2'd2;
    endtask

    always @(negedge clk) begin
        if (!mon_en || !reset) begin
            hold_run = 0;
            rst_run = 0;
        end else begin
            check("rst_n_only_in_write_run_done", cpu_rst_n, load_program[31] | load_ok);
            if (load_program[31]) begin
                if (hold_run == 0) begin
                    if (exp_q.size() == 0) check("unexpected_strobe", load_program, 32'd0);
                    else check("strobe_value", load_program, exp_q.pop_front());
                end
                hold_run++;
                check("rx_ready_in_write", rx_ready, 1'b0);
            end else if (hold_run != 0) begin
                check("hold_len", hold_run, HOLD);
                hold_run = 0;
            end
            if (!load_program[31] && !rx_ready) begin
                rst_run++;
                check("busy_in_cpu_rst", busy, 1'b1);
            end else if (rst_run != 0) begin
                check("cpu_rst_len", rst_run, RST);
                check("load_ok_after_cpu_rst", load_ok, 1'b1);
                rst_run = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input bit gaps);
        bit hdr_seen;
        int k;
        hdr_seen = 1'b0;
        model_frame(f);
        foreach (f[j]) begin
            send_byte(f[j], gaps);
            if (!hdr_seen && f[j] == 8'hA5) begin
                hdr_seen = 1'b1;
                check("restart_cpu_rst_n", cpu_rst_n, 1'b0);
                check("restart_load_ok", load_ok, 1'b0);
                check("restart_err", err_code, 2'd0);
                check("restart_words", words_loaded, 12'd0);
            end
        end
        if (exp_ok) begin
            k = 0;
            while (!load_ok && k < 60) begin @(negedge clk); k++; end
        end else begin
            repeat (HOLD + 4) @(negedge clk);
        end
        check("frame_load_ok", load_ok, exp_ok);
        check("frame_err_code", err_code, exp_err);
        check("frame_words", words_loaded, exp_words);
        check("frame_cpu_rst_n", cpu_rst_n, exp_ok);
        check("frame_strobes_left", exp_q.size(), 0);
    endtask

    function automatic bq_t build(input int cnt, input logic [11:0] addr, input bit bad, input int njunk);
        bq_t f;
        logic [7:0] sum, b;
        for (int i = 0; i < njunk; i++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        f.push_back(8'hA5);
        f.push_back(8'(cnt >> 8));
        f.push_back(8'(cnt));
        f.push_back({4'd0, addr[11:8]});
        f.push_back(addr[7:0]);
        sum = 8'(cnt >> 8) + 8'(cnt) + {4'd0, addr[11:8]} + addr[7:0];
        for (int i = 0; i < 2 * cnt; i++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back(b);
            sum = sum + b;
        end
        b = 8'd0 - sum;
        if (bad) b = b + 8'($urandom_range(1, 255));
        f.push_back(b);
        return f;
    endfunction

    initial begin
        bq_t f1, fbad, fwrap, fzero, ffmt, ffmt2, fj, fr;
        int k;
        f1    = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB8};
        fbad  = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB7};
        fwrap = '{8'hA5, 8'h00, 8'h02, 8'h0F, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE2};
        fzero = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFE};
        ffmt  = '{8'hA5, 8'h10};
        ffmt2 = '{8'hA5, 8'h00, 8'h01, 8'h20};
        fj    = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB8};

        repeat (3) @(negedge clk);
        check("reset_load_program", load_program, 32'd0);
        check("reset_cpu_rst_n", cpu_rst_n, 1'b0);
        check("reset_rx_ready", rx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_load_ok", load_ok, 1'b0);
        check("reset_err_code", err_code, 2'd0);
        check("reset_words", words_loaded, 12'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        model_frame(f1);
        check("pin_single_strobe", exp_q[0], 32'h8100_1234);
        check("pin_single_ok", exp_ok, 1'b1);
        exp_q.delete();
        model_frame(fwrap);
        check("pin_wrap_strobe0", exp_q[0], 32'h8FFF_AABB);
        check("pin_wrap_strobe1", exp_q[1], 32'h8000_CCDD);
        check("pin_wrap_words", exp_words, 12'd2);
        exp_q.delete();
        model_frame(fbad);
        check("pin_bad_err", exp_err, 2'd2);
        exp_q.delete();
        model_frame(ffmt);
        check("pin_fmt_err", exp_err, 2'd1);

        send_frame(f1, 1'b0);
        cpu_done = 1'b1;
        repeat (2) @(negedge clk);
        cpu_done = 1'b0;
        repeat (2) @(negedge clk);
        check("done_cpu_rst_n", cpu_rst_n, 1'b1);
        check("done_load_ok", load_ok, 1'b1);

        send_frame(fbad, 1'b0);
        send_frame(fwrap, 1'b0);
        send_frame(fzero, 1'b0);
        send_frame(ffmt, 1'b0);
        send_frame(ffmt2, 1'b0);
        send_frame(fj, 1'b1);
        send_frame(f1, 1'b0);
        send_frame(fwrap, 1'b1);

        mon_en = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(f1[i], 1'b0);
        k = 0;
        while (!load_program[31] && k < 20) begin @(negedge clk); k++; end
        check("strobe_before_reset", load_program[31], 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("midwrite_reset_load_program", load_program, 32'd0);
        check("midwrite_reset_cpu_rst_n", cpu_rst_n, 1'b0);
        check("midwrite_reset_busy", busy, 1'b0);
        check("midwrite_reset_rx_ready", rx_ready, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        send_frame(f1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                fr = '{8'hA5, 8'($urandom_range(1, 15) << 4)};
            end else begin
                fr = build($urandom_range(0, 5),
                           ($urandom_range(0, 2) == 0) ? 12'hFFE : 12'($urandom_range(0, 4095)),
                           $urandom_range(0, 3) == 0, $urandom_range(0, 2));
            end
            send_frame(fr, $urandom_range(0, 1) == 1);
            if (exp_ok && $urandom_range(0, 1) == 1) begin
                cpu_done = 1'b1;
                @(negedge clk);
                cpu_done = 1'b0;
                @(negedge clk);
                check("rand_done_cpu_rst_n", cpu_rst_n, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
